// File: rtl/proc_pkg.sv
// Shared definitions between decode/issue and the ALU: opcodes, flag bit
// positions, instruction field layout and opcode classification helpers.
package proc_pkg;

   localparam logic [7:0] OP_ADD     = 8'd1;
   localparam logic [7:0] OP_ADI     = 8'd2;
   localparam logic [7:0] OP_XOR     = 8'd9;
   localparam logic [7:0] OP_WR_HI   = 8'd31;
   localparam logic [7:0] OP_POP     = 8'd32;
   localparam logic [7:0] OP_STS     = 8'd35;
   localparam logic [7:0] OP_JCP     = 8'd36;
   localparam logic [7:0] OP_COND_HI = 8'd41;
   localparam logic [7:0] OP_NOP     = 8'd53;

   localparam int FLAG_Z = 4;
   localparam int FLAG_C = 3;
   localparam int FLAG_S = 2;
   localparam int FLAG_P = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic [7:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;   // doubles as the condition code for conditional ops
      logic [11:0] imm;
   } inst_t;

   function automatic logic is_reg_form(input logic [7:0] op);
      case (op)
         8'd1, 8'd3, 8'd5, 8'd8, 8'd9, 8'd11, 8'd13, 8'd15: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

   function automatic logic is_writer(input logic [7:0] op);
      return ((op >= OP_ADD) && (op <= OP_WR_HI)) || (op == OP_POP) || (op == OP_STS);
   endfunction

   function automatic logic is_cond(input logic [7:0] op);
      return (op >= OP_JCP) && (op <= OP_COND_HI);
   endfunction

   function automatic logic is_legal(input logic [7:0] op);
      return (op != 8'd0) && (op <= OP_NOP);
   endfunction

   // Selectors above the V..Z range mean "always"; cond[3] inverts.
   function automatic logic eval_cond(input logic [3:0] cond, input logic [4:0] flags);
      logic t;
      if (cond[2:0] > 3'd4) t = 1'b1;
      else                  t = flags[cond[2:0]];
      return t ^ cond[3];
   endfunction

endpackage

// File: rtl/proc_regfile.sv
// Register file with two asynchronous read ports and one write port; a write
// in the same cycle as a read of the same index is forwarded to the reader.
module proc_regfile #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int IDX_W  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  ra,
   input  logic [IDX_W-1:0]  rb,
   output logic [DATA_W-1:0] da,
   output logic [DATA_W-1:0] db,
   input  logic              we,
   input  logic [IDX_W-1:0]  wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] mem [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we) begin
         mem[wa] <= wd;
      end
   end

   assign da = (we && (wa == ra)) ? wd : mem[ra];
   assign db = (we && (wa == rb)) ? wd : mem[rb];

endmodule

// File: rtl/decode_issue.sv
// Two-stage decode/issue front end for the ALU: a decode register that waits
// out scoreboard hazards, and an issue register that drives the ALU ports.
module decode_issue
   import proc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int IMM_W  = 12
) (
   input  logic              clkout,
   input  logic              rst,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic [31:0]       inst,
   input  logic [4:0]        flags_in,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [7:0]        opcode,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] val,
   output logic              cin,
   output logic              fl,
   output logic [3:0]        issue_rd,
   input  logic              wb_valid,
   input  logic [3:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [7:0]        illegal_cnt
);

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

   logic              vld_p0;
   inst_t             inst_p0;
   logic              vld_p1;
   logic [NREG-1:0]   sb;
   logic [NREG-1:0]   wb_clr;
   logic [NREG-1:0]   sb_eff;
   logic [NREG-1:0]   sb_set;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic              hazard;
   logic              move;

   // A returning writeback releases its dependents in the same cycle.
   assign wb_clr = wb_valid ? (NREG'(1) << wb_rd) : '0;
   assign sb_eff = sb & ~wb_clr;
   assign hazard = sb_eff[inst_p0.rs1] | (is_reg_form(inst_p0.op) & sb_eff[inst_p0.rs2]);
   assign move   = vld_p0 & (~vld_p1 | issue_ready) & ~hazard;
   assign sb_set = (move && is_writer(inst_p0.op)) ? (NREG'(1) << inst_p0.rd) : '0;

   assign inst_ready  = ~rst & (~vld_p0 | move);
   assign issue_valid = vld_p1;

   proc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
      .clk (clkout),
      .rst (rst),
      .ra  (inst_p0.rs1),
      .rb  (inst_p0.rs2),
      .da  (rd_a),
      .db  (rd_b),
      .we  (wb_valid),
      .wa  (wb_rd),
      .wd  (wb_data)
   );

   // Stage D: decode register
   always_ff @(posedge clkout or posedge rst) begin
      if (rst)             vld_p0 <= 1'b0;
      else if (inst_ready) vld_p0 <= inst_valid;
   end

   always_ff @(posedge clkout) begin
      if (inst_valid && inst_ready) inst_p0 <= inst;
   end

   // Scoreboard: a new pending write wins over a same-cycle writeback clear.
   always_ff @(posedge clkout or posedge rst) begin
      if (rst) sb <= '0;
      else     sb <= sb_eff | sb_set;
   end

   // Stage I: issue register feeding the ALU
   always_ff @(posedge clkout or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         opcode      <= OP_NOP;
         A           <= '0;
         B           <= '0;
         val         <= '0;
         cin         <= 1'b0;
         fl          <= 1'b0;
         issue_rd    <= '0;
         illegal_cnt <= '0;
      end else if (move) begin
         vld_p1   <= 1'b1;
         opcode   <= is_legal(inst_p0.op) ? inst_p0.op : OP_NOP;
         A        <= rd_a;
         B        <= rd_b;
         val      <= sext_imm(inst_p0.imm);
         cin      <= flags_in[FLAG_C];
         fl       <= is_cond(inst_p0.op) ? eval_cond(inst_p0.rs2, flags_in) : 1'b0;
         issue_rd <= inst_p0.rd;
         if (!is_legal(inst_p0.op)) illegal_cnt <= sat_inc(illegal_cnt);
      end else if (issue_ready) begin
         vld_p1 <= 1'b0;
      end
   end

endmodule
